// File: rtl/uart_mon_pkg.sv
// -----------------------------------------------------------------------------
// uart_mon_pkg
// Shared definitions for the UART TX monitor:
//   - rx_state_e    : decoder FSM states
//   - NEWLINE_CODE  : byte value that raises the newline pulse
//   - clks_per_bit  : system clocks per serial bit (integer division)
// -----------------------------------------------------------------------------
package uart_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    localparam logic [7:0] NEWLINE_CODE = 8'h0A;

    // Truncating division: the bit period is rounded down to whole clocks.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_mon_fifo.sv
// -----------------------------------------------------------------------------
// uart_mon_fifo
// First-word-fall-through FIFO holding decoded bytes.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : synchronous flush; beats any same-cycle push or pop
//   push_i/wdata_i : write request and data
//   pop_i          : read request (ignored when empty)
//   rdata_o        : head entry, forced to zero while empty
//   empty_o/full_o : occupancy flags
//   push_ok_o      : the push this cycle is stored
//   drop_o         : the push this cycle is discarded because the FIFO is full
// Depth must be a power of two and at least 2 so pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_mon_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             push_ok_o,
    output logic             drop_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] FullCount = (AddrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW-1:0] rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic [AddrW:0]   count_d;
    logic             empty_s;
    logic             full_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             drop_s;

    assign empty_s = (count_q == '0);
    assign full_s  = (count_q == FullCount);

    // Accept/drop decisions and next occupancy.
    always_comb begin
        pop_ok_s  = pop_i && !empty_s && !clear_i;
        // A simultaneous pop frees the slot, so a full FIFO still accepts.
        push_ok_s = push_i && !clear_i && (!full_s || pop_i);
        drop_s    = push_i && !clear_i && full_s && !pop_i;
        count_d   = count_q;
        if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok_s && !push_ok_s) begin
            count_d = count_q - 1'b1;
        end else begin
            count_d = count_q;
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign rdata_o   = empty_s ? '0 : mem_q[rd_ptr_q];
    assign empty_o   = empty_s;
    assign full_o    = full_s;
    assign push_ok_o = push_ok_s;
    assign drop_o    = drop_s;

endmodule

// File: rtl/uart_tx_monitor.sv
// -----------------------------------------------------------------------------
// uart_tx_monitor
// Decodes 8N1 frames from a UART TX line into bytes and queues them in a
// FWFT FIFO with a valid/ready drain port.
// Ports:
//   clk_sys_i, rst_sys_ni : clock, asynchronous active-low reset
//   uart_i                : serial line, idle high
//   byte_o/byte_valid_o   : FIFO head and non-empty flag
//   byte_ready_i          : consumer takes byte_o when valid && ready
//   newline_o             : one-cycle pulse when 0x0A is stored
//   frame_err_o           : sticky, bad stop bit seen
//   overflow_o            : sticky, byte dropped on a full FIFO
//   rx_count_o            : bytes stored, wraps at 2^32
//   clear_i               : synchronous flush of FIFO, flags and count
// -----------------------------------------------------------------------------
module uart_tx_monitor
    import uart_mon_pkg::*;
#(
    parameter int unsigned ClockFrequency = 50_000_000,
    parameter int unsigned BaudRate       = 115_200,
    parameter int unsigned FifoDepth      = 16
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_ni,
    input  logic        uart_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic        newline_o,
    output logic        frame_err_o,
    output logic        overflow_o,
    output logic [31:0] rx_count_o,
    input  logic        clear_i
);

    localparam int unsigned ClksPerBit = clks_per_bit(ClockFrequency, BaudRate);
    localparam int unsigned HalfBit    = ClksPerBit / 2;
    localparam int unsigned CntW       = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] BitReload  = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] HalfReload = CntW'(HalfBit - 1);

    logic [1:0]      sync_q;
    logic            line_s;
    rx_state_e       state_q;
    logic [CntW-1:0] baud_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            frame_err_q;
    logic            cnt_zero_s;
    logic            push_s;
    logic            stop_bad_s;
    logic            push_ok_s;
    logic            drop_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic [31:0]     rx_count_q;
    logic [31:0]     rx_count_d;
    logic            newline_q;
    logic            newline_d;
    logic            overflow_q;
    logic            overflow_d;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_i};
        end
    end

    assign line_s     = sync_q[1];
    assign cnt_zero_s = (baud_cnt_q == '0);

    // Stop-bit outcome, decoded from registered FSM state.
    always_comb begin
        push_s     = 1'b0;
        stop_bad_s = 1'b0;
        if ((state_q == ST_STOP) && cnt_zero_s) begin
            push_s     = line_s;
            stop_bad_s = !line_s;
        end else begin
            push_s     = 1'b0;
            stop_bad_s = 1'b0;
        end
    end

    // Frame decoder FSM with the sticky framing-error flag.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q     <= ST_IDLE;
            baud_cnt_q  <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            // clear_i wins over a same-cycle framing error.
            if (clear_i) begin
                frame_err_q <= 1'b0;
            end else if (stop_bad_s) begin
                frame_err_q <= 1'b1;
            end else begin
                frame_err_q <= frame_err_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!line_s) begin
                        // First sample lands mid start bit.
                        state_q    <= ST_START;
                        baud_cnt_q <= HalfReload;
                    end else begin
                        baud_cnt_q <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_zero_s) begin
                        if (!line_s) begin
                            state_q    <= ST_DATA;
                            baud_cnt_q <= BitReload;
                            bit_idx_q  <= 3'd0;
                        end else begin
                            // Line already back high: a glitch, not a frame.
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_zero_s) begin
                        shift_q[bit_idx_q] <= line_s;
                        baud_cnt_q         <= BitReload;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_zero_s) begin
                        state_q <= line_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Hold off until the line idles so a long low is not
                    // mistaken for a stream of start bits.
                    if (line_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_BREAK;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    baud_cnt_q <= '0;
                end
            endcase
        end
    end

    uart_mon_fifo #(
        .Depth (FifoDepth),
        .Width (8)
    ) u_fifo (
        .clk_i     (clk_sys_i),
        .rst_ni    (rst_sys_ni),
        .clear_i   (clear_i),
        .push_i    (push_s),
        .wdata_i   (shift_q),
        .pop_i     (byte_ready_i),
        .rdata_o   (byte_o),
        .empty_o   (fifo_empty_s),
        .full_o    (fifo_full_s),
        .push_ok_o (push_ok_s),
        .drop_o    (drop_s)
    );

    // Next values of the status outputs; push_ok/drop are already clear-gated.
    always_comb begin
        rx_count_d = rx_count_q;
        newline_d  = 1'b0;
        overflow_d = overflow_q;
        if (clear_i) begin
            rx_count_d = 32'd0;
            newline_d  = 1'b0;
            overflow_d = 1'b0;
        end else begin
            rx_count_d = push_ok_s ? (rx_count_q + 32'd1) : rx_count_q;
            newline_d  = push_ok_s && (shift_q == NEWLINE_CODE);
            overflow_d = overflow_q || drop_s;
        end
    end

    // Status output registers.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            rx_count_q <= 32'd0;
            newline_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rx_count_q <= rx_count_d;
            newline_q  <= newline_d;
            overflow_q <= overflow_d;
        end
    end

    assign byte_valid_o = !fifo_empty_s;
    assign newline_o    = newline_q;
    assign frame_err_o  = frame_err_q;
    assign overflow_o   = overflow_q;
    assign rx_count_o   = rx_count_q;

endmodule

// File: tb/tb_uart_tx_monitor.sv
module tb_uart_tx_monitor;

    // 40 clocks per bit keeps the run short; half bit = 20.
    localparam int unsigned CLK_HZ = 4_608_000;
    localparam int unsigned BAUD   = 115_200;
    localparam int          CPB    = 40;
    localparam int          DEPTH  = 16;

    logic        clk_sys_i    = 1'b0;
    logic        rst_sys_ni   = 1'b0;
    logic        uart_i       = 1'b1;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic        byte_ready_i = 1'b0;
    logic        newline_o;
    logic        frame_err_o;
    logic        overflow_o;
    logic [31:0] rx_count_o;
    logic        clear_i      = 1'b0;

    always #5 clk_sys_i = ~clk_sys_i;

    uart_tx_monitor #(
        .ClockFrequency (CLK_HZ),
        .BaudRate       (BAUD),
        .FifoDepth      (DEPTH)
    ) dut (
        .clk_sys_i    (clk_sys_i),
        .rst_sys_ni   (rst_sys_ni),
        .uart_i       (uart_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .newline_o    (newline_o),
        .frame_err_o  (frame_err_o),
        .overflow_o   (overflow_o),
        .rx_count_o   (rx_count_o),
        .clear_i      (clear_i)
    );

    int          checks = 0;
    int          errors = 0;
    // Reference model: bytes the FIFO should hold, in order, plus flag state.
    logic [7:0]  exp_q[$];
    int          exp_count = 0;
    int          exp_nl    = 0;
    int          nl_seen   = 0;
    logic        exp_ovf   = 1'b0;
    logic        exp_ferr  = 1'b0;
    logic        rand_ready_en = 1'b0;
    logic        ready_cfg     = 1'b0;
    logic [7:0]  mon_exp;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys_i);
        #1;
    endtask

    // A correctly framed byte is stored unless the model FIFO is already full.
    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(b);
            exp_count++;
            if (b == 8'h0A) exp_nl++;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_count = 0;
        exp_ovf   = 1'b0;
        exp_ferr  = 1'b0;
    endtask

    // Drive one 8N1 frame; the model is updated mid stop bit, just before
    // the DUT samples it, so the monitor never sees a byte ahead of the model.
    task automatic send_frame(input logic [7:0] b, input logic good_stop);
        uart_i = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_i = b[i];
            cyc(CPB);
        end
        uart_i = good_stop;
        cyc(CPB / 2);
        if (good_stop) model_push(b);
        else exp_ferr = 1'b1;
        cyc(CPB - CPB / 2);
        uart_i = 1'b1;
        cyc(good_stop ? 2 : CPB);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200 * CPB) begin
            cyc(1);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        cyc(3);
        chk("valid_after_drain", byte_valid_o, 1'b0);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_rx_count"}, rx_count_o, exp_count);
        chk({tag, "_frame_err"}, frame_err_o, exp_ferr);
        chk({tag, "_overflow"}, overflow_o, exp_ovf);
        chk({tag, "_newlines"}, nl_seen, exp_nl);
    endtask

    // Ready driver: fixed level or random per cycle.
    always @(posedge clk_sys_i) begin
        #1;
        if (rand_ready_en) byte_ready_i = ($urandom_range(0, 1) == 1);
        else byte_ready_i = ready_cfg;
    end

    // Monitor: every handshake pops the scoreboard; newline pulses are counted.
    always @(negedge clk_sys_i) begin
        if (rst_sys_ni && byte_valid_o && byte_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte got=%0h exp=none", byte_o);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("byte", byte_o, mon_exp);
            end
        end
        if (rst_sys_ni && newline_o) nl_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int         lat;
        logic [7:0] b;

        // Reset values.
        cyc(4);
        chk("rst_valid", byte_valid_o, 1'b0);
        chk("rst_byte", byte_o, 8'h00);
        chk("rst_newline", newline_o, 1'b0);
        check_status("rst");
        rst_sys_ni = 1'b1;
        ready_cfg  = 1'b1;
        cyc(CPB);

        // Single byte and its latency from the start edge.
        lat = 0;
        fork
            send_frame(8'h41, 1'b1);
            begin
                while (!byte_valid_o && lat < 20 * CPB) begin
                    @(negedge clk_sys_i);
                    lat++;
                end
            end
        join
        chk("latency_in_window", (lat >= (19 * CPB) / 2) && (lat <= (19 * CPB) / 2 + 6), 1'b1);
        wait_drain();
        check_status("a41");

        // "OK\n"
        send_frame(8'h4F, 1'b1);
        send_frame(8'h4B, 1'b1);
        send_frame(8'h0A, 1'b1);
        wait_drain();
        check_status("ok_nl");

        // Bad stop bit, then a good byte.
        send_frame(8'h55, 1'b0);
        cyc(5);
        check_status("ferr");
        send_frame(8'h33, 1'b1);
        wait_drain();
        check_status("after_ferr");

        // Short glitch from idle; a following byte must still decode.
        uart_i = 1'b0;
        cyc(CPB / 4);
        uart_i = 1'b1;
        cyc(2 * CPB);
        chk("glitch_valid", byte_valid_o, 1'b0);
        check_status("glitch");
        send_frame(8'hC3, 1'b1);
        wait_drain();

        // clear_i empties the FIFO and drops the sticky flags.
        ready_cfg = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        cyc(3);
        chk("pre_clear_valid", byte_valid_o, 1'b1);
        clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        model_clear();
        cyc(2);
        chk("clear_valid", byte_valid_o, 1'b0);
        check_status("clear");

        // Overflow: 17 bytes into a 16-deep FIFO with no drain.
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
        end
        cyc(3);
        chk("ovf_valid", byte_valid_o, 1'b1);
        check_status("ovf");
        ready_cfg = 1'b1;
        wait_drain();
        clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        model_clear();
        cyc(2);
        check_status("ovf_clear");

        // Random bytes, gaps and back-pressure.
        rand_ready_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = (i == 3) ? 8'h0A : 8'($urandom);
            send_frame(b, 1'b1);
            cyc($urandom_range(0, 3 * CPB));
        end
        rand_ready_en = 1'b0;
        ready_cfg     = 1'b1;
        wait_drain();
        check_status("random");

        // Reset in the middle of the data bits.
        ready_cfg = 1'b0;
        send_frame(8'h5A, 1'b1);
        uart_i = 1'b0;
        cyc(CPB);
        uart_i = 1'b1;
        cyc(CPB);
        uart_i = 1'b0;
        cyc(CPB / 2);
        rst_sys_ni = 1'b0;
        uart_i     = 1'b1;
        model_clear();
        cyc(3);
        chk("midrst_valid", byte_valid_o, 1'b0);
        chk("midrst_byte", byte_o, 8'h00);
        chk("midrst_newline", newline_o, 1'b0);
        check_status("midrst");
        rst_sys_ni = 1'b1;
        ready_cfg  = 1'b1;
        cyc(2 * CPB);
        send_frame(8'hA5, 1'b1);
        wait_drain();
        check_status("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
